// File: rtl/store_sequencer_pkg.sv
// Shared types for the data-memory store sequencer: store ops, FSM states
// and the access size of each op.
package store_sequencer_pkg;

  typedef enum logic [1:0] {
    STORE_OP_SB = 2'd0,
    STORE_OP_SH = 2'd1,
    STORE_OP_SW = 2'd2
  } StoreOp_t;

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} StoreSeqState_t;

  localparam logic [2:0] STORE_SIZE_SB = 3'd1;
  localparam logic [2:0] STORE_SIZE_SH = 3'd2;
  localparam logic [2:0] STORE_SIZE_SW = 3'd4;

endpackage

// File: rtl/store_sequencer_lane_gen.sv
// Combinational lane generator: positions store data and byte enables across
// two adjacent words, flagging word-crossing stores and unknown ops.
module store_lane_gen
  import store_sequencer_pkg::*;
(
  input  logic [1:0]  i_off,
  input  StoreOp_t    i_op,
  input  logic [31:0] i_data,
  output logic [7:0]  o_wide_mask,
  output logic [63:0] o_wide_data,
  output logic        o_split,
  output logic        o_valid_op
);

  logic [2:0]  w_sz;
  logic [3:0]  w_base;
  logic [31:0] w_data_m;

  always_comb begin
    w_sz       = 3'd0;
    o_valid_op = 1'b0;
    case (i_op)
      STORE_OP_SB: begin w_sz = STORE_SIZE_SB; o_valid_op = 1'b1; end
      STORE_OP_SH: begin w_sz = STORE_SIZE_SH; o_valid_op = 1'b1; end
      STORE_OP_SW: begin w_sz = STORE_SIZE_SW; o_valid_op = 1'b1; end
      default:     begin w_sz = 3'd0;          o_valid_op = 1'b0; end
    endcase
  end

  // Bits above the access size are cleared so unused lanes always carry 0.
  assign w_base   = 4'((5'd1 << w_sz) - 5'd1);
  assign w_data_m = i_data & {{8{w_base[3]}}, {8{w_base[2]}}, {8{w_base[1]}}, {8{w_base[0]}}};

  assign o_wide_mask = {4'b0000, w_base} << i_off;
  assign o_wide_data = {32'h0, w_data_m} << {i_off, 3'b000};
  assign o_split     = |o_wide_mask[7:4];

endmodule

// File: rtl/store_sequencer.sv
// Store sequencer: turns one core store request into one or two word-aligned
// bus write beats and reports completion with a single done pulse.
//   state | meaning
//   IDLE  | ready for a new store
//   LO    | low (or only) beat on the bus
//   HI    | high beat of a word-crossing store
//   FIN   | done pulse, err as latched
module store_sequencer
  import store_sequencer_pkg::*;
#(
  parameter logic ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  StoreOp_t    req_store_op,
  input  logic [31:0] req_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        done,
  output logic        err
);

  StoreSeqState_t r_state;
  logic        r_split;
  logic [31:0] r_hi_data;
  logic [3:0]  r_hi_mask;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wmask;
  logic        r_done;
  logic        r_err;

  logic [7:0]  w_wide_mask;
  logic [63:0] w_wide_data;
  logic        w_split;
  logic        w_valid_op;

  store_lane_gen u_lane_gen (
    .i_off       (req_addr[1:0]),
    .i_op        (req_store_op),
    .i_data      (req_data),
    .o_wide_mask (w_wide_mask),
    .o_wide_data (w_wide_data),
    .o_split     (w_split),
    .o_valid_op  (w_valid_op)
  );

  assign req_ready = resetn && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_split     <= 1'b0;
      r_hi_data   <= '0;
      r_hi_mask   <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          if (!w_valid_op || (w_split && !ALLOW_MISALIGNED)) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_state     <= LO;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {req_addr[31:2], 2'b00};
            r_mem_wdata <= w_wide_data[31:0];
            r_mem_wmask <= w_wide_mask[3:0];
            r_split     <= w_split;
            r_hi_data   <= w_wide_data[63:32];
            r_hi_mask   <= w_wide_mask[7:4];
          end
        end
        LO: if (mem_ready) begin
          if (r_split) begin
            r_state     <= HI;
            r_mem_addr  <= r_mem_addr + 32'd4;
            r_mem_wdata <= r_hi_data;
            r_mem_wmask <= r_hi_mask;
          end else begin
            r_state     <= FIN;
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        HI: if (mem_ready) begin
          r_state     <= FIN;
          r_mem_valid <= 1'b0;
          r_done      <= 1'b1;
        end
        FIN: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_store_sequencer.sv
// Scoreboard bench for store_sequencer: directed stores push expected beats
// and done events; a negedge monitor pops and compares them.
module tb_store_sequencer;
  import store_sequencer_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid, req_ready, mem_valid, mem_ready, done, err;
  logic [31:0] req_addr, req_data, mem_addr, mem_wdata;
  StoreOp_t    req_store_op;
  logic [3:0]  mem_wmask;

  logic        req_valid_2, req_ready_2, mem_valid_2, done_2, err_2;
  logic        mem_ready_2 = 1'b1;
  logic [31:0] req_addr_2, req_data_2, mem_addr_2, mem_wdata_2;
  StoreOp_t    req_store_op_2;
  logic [3:0]  mem_wmask_2;

  store_sequencer #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_store_op(req_store_op), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .done(done), .err(err)
  );

  store_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .resetn(resetn), .req_valid(req_valid_2), .req_ready(req_ready_2),
    .req_addr(req_addr_2), .req_store_op(req_store_op_2), .req_data(req_data_2),
    .mem_valid(mem_valid_2), .mem_ready(mem_ready_2), .mem_addr(mem_addr_2),
    .mem_wdata(mem_wdata_2), .mem_wmask(mem_wmask_2), .done(done_2), .err(err_2)
  );

  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] mask;} beat_t;
  typedef struct {logic err; int cyc;} done_t;
  beat_t beat_q[$];
  done_t done_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    beat_t b;
    b.addr = a; b.data = d; b.mask = m;
    return b;
  endfunction

  // Inputs change 1 time unit after the rising edge; monitor samples at negedge.
  task automatic drv_wait();
    @(posedge clk);
    #1;
  endtask

  logic        pv = 1'b0, phs = 1'b0;
  logic [31:0] pa, pd;
  logic [3:0]  pm;
  beat_t       mb;
  done_t       md;
  logic        saw_valid_2 = 1'b0;

  always @(negedge clk) begin
    if (mem_valid_2) saw_valid_2 = 1'b1;
    if (!resetn) begin
      pv = 1'b0;
      phs = 1'b0;
    end else begin
      if (mem_valid) begin
        chk("wmask_nonzero", 64'(mem_wmask == 4'd0), 64'd0);
        if (pv && !phs) begin
          chk("hold_addr", mem_addr, pa);
          chk("hold_wdata", mem_wdata, pd);
          chk("hold_wmask", mem_wmask, pm);
        end
        if (mem_ready) begin
          if (beat_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
          else begin
            mb = beat_q.pop_front();
            chk("beat_addr", mem_addr, mb.addr);
            chk("beat_wdata", mem_wdata, mb.data);
            chk("beat_wmask", mem_wmask, mb.mask);
          end
        end
      end else if (pv && !phs) begin
        chk("valid_dropped_without_handshake", 64'd1, 64'd0);
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          md = done_q.pop_front();
          chk("done_err", err, md.err);
          chk("done_cycle", 64'(cyc), 64'(md.cyc));
        end
      end
      pv = mem_valid; pa = mem_addr; pd = mem_wdata; pm = mem_wmask;
      phs = mem_valid && mem_ready;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [1:0] op, input logic [31:0] d,
                       input int nb, input beat_t b0, input beat_t b1,
                       input bit exp_done, input logic exp_err, input int lat, output int t);
    int n;
    done_t de;
    req_addr = a; req_store_op = StoreOp_t'(op); req_data = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin drv_wait(); n++; end
    t = cyc;
    if (!req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    if (nb > 0) beat_q.push_back(b0);
    if (nb > 1) beat_q.push_back(b1);
    if (exp_done) begin de.err = exp_err; de.cyc = t + lat; done_q.push_back(de); end
    drv_wait();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((beat_q.size() != 0 || done_q.size() != 0) && n < 60) begin drv_wait(); n++; end
    chk("drain_pending", 64'(beat_q.size() + done_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2;
    beat_t z;
    z = mk(32'h0, 32'h0, 4'h0);
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_store_op = STORE_OP_SB; mem_ready = 1'b1;
    req_valid_2 = 1'b0; req_addr_2 = '0; req_data_2 = '0; req_store_op_2 = STORE_OP_SB;
    repeat (3) drv_wait();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ready", req_ready, 0);
    resetn = 1'b1;
    drv_wait();
    chk("req_ready_after_reset", req_ready, 1);

    // Two back-to-back aligned stores: one every 3 cycles.
    issue(32'h0000_1003, 2'd0, 32'h0000_00AB, 1, mk(32'h1000, 32'hAB00_0000, 4'b1000), z, 1, 0, 2, t1);
    issue(32'h0000_7000, 2'd0, 32'h1234_5678, 1, mk(32'h7000, 32'h0000_0078, 4'b0001), z, 1, 0, 2, t2);
    chk("throughput_gap", 64'(t2 - t1), 64'd3);
    drain();

    issue(32'h0000_2002, 2'd2, 32'h1122_3344, 2, mk(32'h2000, 32'h3344_0000, 4'b1100),
          mk(32'h2004, 32'h0000_1122, 4'b0011), 1, 0, 3, t);
    drain();
    issue(32'hFFFF_FFFE, 2'd2, 32'hA1B2_C3D4, 2, mk(32'hFFFF_FFFC, 32'hC3D4_0000, 4'b1100),
          mk(32'h0000_0000, 32'h0000_A1B2, 4'b0011), 1, 0, 3, t);
    drain();
    issue(32'h0000_5000, 2'd2, 32'hDEAD_BEEF, 1, mk(32'h5000, 32'hDEAD_BEEF, 4'b1111), z, 1, 0, 2, t);
    issue(32'h0000_6002, 2'd1, 32'hFFFF_1234, 1, mk(32'h6000, 32'h1234_0000, 4'b1100), z, 1, 0, 2, t);
    issue(32'h0000_8001, 2'd1, 32'h0000_CAFE, 1, mk(32'h8000, 32'h00CA_FE00, 4'b0110), z, 1, 0, 2, t);
    issue(32'h0000_9000, 2'd3, 32'h5555_5555, 0, z, z, 1, 1, 1, t);
    drain();

    // Split SH with the first beat stalled for three cycles.
    mem_ready = 1'b0;
    issue(32'h0000_3003, 2'd1, 32'h0000_BEEF, 2, mk(32'h3000, 32'hEF00_0000, 4'b1000),
          mk(32'h3004, 32'h0000_00BE, 4'b0001), 1, 0, 6, t);
    repeat (3) drv_wait();
    mem_ready = 1'b1;
    drain();

    // Strict instance rejects a word-crossing SW without touching the bus.
    chk("strict_ready", req_ready_2, 1);
    req_addr_2 = 32'h0000_4001; req_store_op_2 = STORE_OP_SW; req_data_2 = 32'h0102_0304;
    req_valid_2 = 1'b1;
    drv_wait();
    req_valid_2 = 1'b0;
    chk("strict_done_t1", done_2, 1);
    chk("strict_err_t1", err_2, 1);
    drv_wait();
    chk("strict_done_cleared", done_2, 0);
    chk("strict_no_mem_valid", saw_valid_2, 0);

    // Reset while the high beat is stalled.
    issue(32'h0000_2002, 2'd2, 32'h1122_3344, 1, mk(32'h2000, 32'h3344_0000, 4'b1100), z, 0, 0, 0, t);
    drv_wait();
    mem_ready = 1'b0;
    chk("hi_beat_addr_before_reset", mem_addr, 32'h2004);
    drv_wait();
    resetn = 1'b0;
    drv_wait();
    chk("midreset_mem_valid", mem_valid, 0);
    chk("midreset_done", done, 0);
    chk("midreset_req_ready", req_ready, 0);
    resetn = 1'b1;
    mem_ready = 1'b1;
    drv_wait();
    chk("post_reset_req_ready", req_ready, 1);
    chk("post_reset_mem_valid", mem_valid, 0);
    chk("queues_empty_end", 64'(beat_q.size() + done_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
